// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin output mux.
package mux_arb_pkg;
   localparam int NREQ = 4;

   typedef logic [3:0] word_t;
   typedef logic [1:0] sel_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/mux_4_1.sv
// 4:1 word multiplexer built from AND/OR/NOT terms only.
module mux_4_1
   import mux_arb_pkg::*;
(
   input  word_t d0,
   input  word_t d1,
   input  word_t d2,
   input  word_t d3,
   input  sel_t  sel,
   output word_t y
);
   word_t s0;
   word_t s1;

   assign s0 = {4{sel[0]}};
   assign s1 = {4{sel[1]}};

   assign y = (d0 & ~s1 & ~s0) |
              (d1 & ~s1 &  s0) |
              (d2 &  s1 & ~s0) |
              (d3 &  s1 &  s0);
endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry output register through mux_4_1.
// Optional burst lock on in_last is enabled by defining MUX_ARB_LOCK_EN.
//
// state | meaning
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word (out_valid=1)
module mux_4_1_rr_arbiter
   import mux_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       in_valid,
   input  word_t [NREQ-1:0]      in_data,
   input  logic [NREQ-1:0]       in_last,
   output logic [NREQ-1:0]       in_ready,
   output logic                  out_valid,
   output word_t                 out_data,
   output sel_t                  out_sel,
   input  logic                  out_ready
);
   state_t state_q,    state_d;
   word_t  out_data_q, out_data_d;
   sel_t   out_sel_q,  out_sel_d;
   sel_t   rr_last_q,  rr_last_d;
`ifdef MUX_ARB_LOCK_EN
   logic   lock_q,     lock_d;
   sel_t   lock_sel_q, lock_sel_d;
`else
   logic   unused_last;
   assign unused_last = ^in_last;
`endif

   logic   can_load;
   logic   grant_vld;
   sel_t   grant_idx;
   sel_t   cand;
   logic   xfer_in;
   word_t  mux_y;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_last_q + sel_t'(k);
         if (!grant_vld && in_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
`ifdef MUX_ARB_LOCK_EN
      // A locked burst owns the channel even while its requester is idle.
      if (lock_q) begin
         grant_vld = 1'b1;
         grant_idx = lock_sel_q;
      end
`endif
   end

   // Holding reset also blocks loading so no requester sees ready.
   assign can_load  = rst & (~out_valid | out_ready);
   assign in_ready  = {NREQ{can_load & grant_vld}} & (4'b0001 << grant_idx);
   assign xfer_in   = |(in_valid & in_ready);
   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

   mux_4_1 u_mux (
      .d0  (in_data[0]),
      .d1  (in_data[1]),
      .d2  (in_data[2]),
      .d3  (in_data[3]),
      .sel (grant_idx),
      .y   (mux_y)
   );

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      rr_last_d  = rr_last_q;
`ifdef MUX_ARB_LOCK_EN
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
`endif
      case (state_q)
         EMPTY: if (xfer_in) state_d = FULL;
         FULL:  if (!xfer_in && out_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (xfer_in) begin
         out_data_d = mux_y;
         out_sel_d  = grant_idx;
`ifdef MUX_ARB_LOCK_EN
         if (in_last[grant_idx]) begin
            lock_d    = 1'b0;
            rr_last_d = grant_idx;
         end else begin
            lock_d     = 1'b1;
            lock_sel_d = grant_idx;
         end
`else
         rr_last_d = grant_idx;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_sel_q  <= '0;
         rr_last_q  <= 2'd3;
`ifdef MUX_ARB_LOCK_EN
         lock_q     <= 1'b0;
         lock_sel_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
         rr_last_q  <= rr_last_d;
`ifdef MUX_ARB_LOCK_EN
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
`endif
      end
   end
endmodule
